// File: rtl/pointwise_sub_sched_if.sv
// Request/grant and operand/result bundle between requesters and the pointwise-subtract scheduler.
interface pointwise_sub_sched_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_ELEM = 16
);
    localparam int unsigned VEC_W = NUM_ELEM * DATA_W;

    logic [1:0]       req;
    logic [VEC_W-1:0] vec1_0;
    logic [VEC_W-1:0] vec2_0;
    logic [VEC_W-1:0] vec1_1;
    logic [VEC_W-1:0] vec2_1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [VEC_W-1:0] result;

    modport master (
        output req, vec1_0, vec2_0, vec1_1, vec2_1,
        input  gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, vec1_0, vec2_0, vec1_1, vec2_1,
        output gnt, busy, done, done_id, result
    );
endinterface

// File: rtl/pointwise_sub_sched.sv
// Round-robin scheduler sharing one LANES-wide subtract lane between two requesters;
// captures operands on grant, subtracts beat-serially, pulses done with the owner id.
module pointwise_sub_sched #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_ELEM = 16,
    parameter int unsigned LANES    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pointwise_sub_sched_if.slave        bus
);
    localparam int unsigned VEC_W  = NUM_ELEM * DATA_W;
    localparam int unsigned BEATS  = NUM_ELEM / LANES;
    localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((NUM_ELEM % LANES) != 0) begin : g_bad_lanes
            $error("pointwise_sub_sched: NUM_ELEM must be a multiple of LANES");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [BCNT_W-1:0] beat_q, beat_d;
    logic [VEC_W-1:0]  op1_q, op1_d;
    logic [VEC_W-1:0]  op2_q, op2_d;
    logic [VEC_W-1:0]  result_q, result_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              done_id_q, done_id_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        gnt_c;
    logic              winner_c;

    // Lone requester wins; on a tie the one not served last wins.
    always_comb begin
        winner_c = ~last_q;
        if (bus.req == 2'b01) winner_c = 1'b0;
        if (bus.req == 2'b10) winner_c = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        result_d  = result_q;
        owner_d   = owner_q;
        last_d    = last_q;
        done_id_d = done_id_q;
        done_d    = 1'b0;
        gnt_c     = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (rst_n && (bus.req != 2'b00)) begin
                    gnt_c   = winner_c ? 2'b10 : 2'b01;
                    op1_d   = winner_c ? bus.vec1_1 : bus.vec1_0;
                    op2_d   = winner_c ? bus.vec2_1 : bus.vec2_0;
                    owner_d = winner_c;
                    last_d  = winner_c;
                    beat_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Lane j of this beat handles element beat*LANES + j; wraps modulo 2^DATA_W.
                for (int unsigned j = 0; j < LANES; j++) begin
                    result_d[(32'(beat_q) * LANES + j) * DATA_W +: DATA_W] =
                        op1_q[(32'(beat_q) * LANES + j) * DATA_W +: DATA_W] -
                        op2_q[(32'(beat_q) * LANES + j) * DATA_W +: DATA_W];
                end
                beat_d = beat_q + BCNT_W'(1);
                if (beat_q == BCNT_W'(BEATS - 1)) begin
                    beat_d    = '0;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            result_q  <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            done_id_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            result_q  <= result_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            done_id_q <= done_id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_pointwise_sub_sched.sv
// Directed bench for pointwise_sub_sched at DATA_W=16, NUM_ELEM=8, LANES=2 (four beats per job).
module tb_pointwise_sub_sched;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pointwise_sub_sched_if #(.DATA_W(16), .NUM_ELEM(8)) bus ();

    pointwise_sub_sched #(.DATA_W(16), .NUM_ELEM(8), .LANES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] ramp(input int m);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(m * i);
        return r;
    endfunction

    function automatic logic [127:0] fill(input logic [15:0] ev, input logic [15:0] od);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = (i % 2 == 0) ? ev : od;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for the grant, then follow the job through to done.
    task automatic job(input string tag, input logic [1:0] rq, input logic w, input int exp_wait,
                       input logic [127:0] a0, input logic [127:0] b0,
                       input logic [127:0] a1, input logic [127:0] b1,
                       input logic [127:0] res, input logic [1:0] rq_after, input bit chg);
        int waited;
        waited      = 0;
        bus.req     = rq;
        bus.vec1_0  = a0;
        bus.vec2_0  = b0;
        bus.vec1_1  = a1;
        bus.vec2_1  = b1;
        #1;
        while (bus.gnt == 2'b00 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        chk({tag, ":gnt"}, 128'(bus.gnt), w ? 128'd2 : 128'd1);
        if (exp_wait >= 0) chk({tag, ":wait"}, 128'(waited), 128'(exp_wait));
        @(negedge clk);
        bus.req = rq_after;
        if (chg) bus.vec1_0 = '1;
        #1;
        for (int c = 1; c <= 5; c++) begin
            chk({tag, ":busy"}, 128'(bus.busy), 128'd1);
            chk({tag, ":gnt_run"}, 128'(bus.gnt), 128'd0);
            chk({tag, ":done"}, 128'(bus.done), (c == 5) ? 128'd1 : 128'd0);
            if (c == 5) begin
                chk({tag, ":done_id"}, 128'(bus.done_id), 128'(w));
                chk({tag, ":result"}, bus.result, res);
            end else begin
                @(negedge clk); #1;
            end
        end
        @(negedge clk); #1;
        chk({tag, ":idle_busy"}, 128'(bus.busy), 128'd0);
        chk({tag, ":idle_done"}, 128'(bus.done), 128'd0);
        chk({tag, ":held_id"}, 128'(bus.done_id), 128'(w));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.req    = 2'b11;
        bus.vec1_0 = ramp(3);
        bus.vec2_0 = ramp(1);
        bus.vec1_1 = ramp(4);
        bus.vec2_1 = ramp(2);

        // Reset held for three cycles with both requests up.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst:gnt", 128'(bus.gnt), 128'd0);
            chk("rst:busy", 128'(bus.busy), 128'd0);
            chk("rst:done", 128'(bus.done), 128'd0);
            chk("rst:result", bus.result, 128'd0);
        end
        chk("rst:done_id", 128'(bus.done_id), 128'd0);
        rst_n = 1'b1;

        job("single", 2'b01, 1'b0, 0, ramp(10), ramp(1), '0, '0, ramp(9), 2'b00, 1'b0);
        job("wrap", 2'b10, 1'b1, 0, '0, '0, fill(16'h8000, 16'h0000), fill(16'h0001, 16'h0001),
            fill(16'h7FFF, 16'hFFFF), 2'b10, 1'b0);
        job("rep1", 2'b10, 1'b1, 0, '0, '0, ramp(5), ramp(7), ramp(-2), 2'b00, 1'b0);
        job("rr0", 2'b11, 1'b0, 0, ramp(100), ramp(3), fill(16'h1234, 16'h0000),
            fill(16'h0000, 16'h1234), ramp(97), 2'b11, 1'b1);
        job("rr1", 2'b11, 1'b1, 0, ramp(100), ramp(3), fill(16'h1234, 16'h0000),
            fill(16'h0000, 16'h1234), fill(16'h1234, 16'hEDCC), 2'b11, 1'b0);
        job("rr2", 2'b11, 1'b0, 0, ramp(3), ramp(4), ramp(20), ramp(13), ramp(-1), 2'b11, 1'b0);
        job("rr3", 2'b11, 1'b1, 0, ramp(3), ramp(4), ramp(20), ramp(13), ramp(7), 2'b11, 1'b0);

        // Abort a job in its third beat with reset.
        bus.req    = 2'b11;
        bus.vec1_0 = ramp(50);
        bus.vec2_0 = ramp(1);
        #1;
        chk("abort:gnt", 128'(bus.gnt), 128'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 2'b00;
        #1;
        chk("abort:busy_before", 128'(bus.busy), 128'd1);
        @(negedge clk); #1;
        chk("abort:busy", 128'(bus.busy), 128'd0);
        chk("abort:done", 128'(bus.done), 128'd0);
        chk("abort:result", bus.result, 128'd0);
        chk("abort:gnt_rst", 128'(bus.gnt), 128'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("abort:no_done", 128'(bus.done), 128'd0);
            chk("abort:idle", 128'(bus.busy), 128'd0);
        end

        job("rst_rr", 2'b11, 1'b0, 0, ramp(6), ramp(2), '0, '0, ramp(4), 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
